aes_sub_bytes_seq: RTL



---
 rtl/aes_sub_bytes_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/aes_sub_bytes_seq.sv
// Time-multiplexed AES SubBytes: 16 bytes pushed through LANES S-box lanes over
// 16/LANES beats, with valid/ready on both sides and optional inverse S-box.

module aes_gf_inv (
  input  logic [7:0] i_a,
  output logic [7:0] o_inv
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    r  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // a^254 by square-and-multiply; maps 0 to 0 as SubBytes requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  assign o_inv = gf_inv(i_a);
endmodule

module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  logic [7:0] w_b;

  aes_gf_inv u_inv (.i_a(i_byte), .o_inv(w_b));

  assign o_byte = w_b ^ {w_b[6:0], w_b[7]} ^ {w_b[5:0], w_b[7:6]}
                ^ {w_b[4:0], w_b[7:5]} ^ {w_b[3:0], w_b[7:4]} ^ 8'h63;
endmodule

module aes_inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  logic [7:0] w_b;

  // inverse affine first, then field inversion
  assign w_b = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]}
             ^ {i_byte[1:0], i_byte[7:2]} ^ 8'h05;

  aes_gf_inv u_inv (.i_a(w_b), .o_inv(o_byte));
endmodule

module aes_sub_bytes_lane #(
  parameter int INV_EN = 1
) (
  input  logic       i_mode,
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  logic [7:0] w_fwd;

  aes_sbox u_fwd (.i_byte(i_byte), .o_byte(w_fwd));

  if (INV_EN != 0) begin : g_inv
    logic [7:0] w_inv;
    aes_inv_sbox u_inv (.i_byte(i_byte), .o_byte(w_inv));
    assign o_byte = i_mode ? w_inv : w_fwd;
  end else begin : g_fwd
    assign o_byte = w_fwd;
  end
endmodule

module aes_sub_bytes_seq #(
  parameter int LANES  = 4,
  parameter int INV_EN = 1
) (
  input  logic         i_aes_clk,
  input  logic         i_aes_rst_n,
  input  logic         i_aes_sub_bytes_seq_valid,
  output logic         o_aes_sub_bytes_seq_ready,
  input  logic         i_aes_sub_bytes_seq_inv,
  input  logic [127:0] i_aes_sub_bytes_seq_data_in,
  output logic         o_aes_sub_bytes_seq_valid,
  input  logic         i_aes_sub_bytes_seq_ready,
  output logic [127:0] o_aes_sub_bytes_seq_data_out,
  output logic         o_aes_sub_bytes_seq_busy
);
  localparam int BEATS = 16 / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_mode;
  // beat-major view: byte k = beat*LANES + lane, matching the flat bus layout
  logic [BEATS-1:0][LANES-1:0][7:0] r_src, r_res;
  logic [LANES-1:0][7:0] w_lane_in, w_lane_out;

  assign w_lane_in = r_src[r_cnt];

  aes_sub_bytes_lane #(.INV_EN(INV_EN)) u_lane [LANES-1:0] (
    .i_mode (r_mode),
    .i_byte (w_lane_in),
    .o_byte (w_lane_out)
  );

  always_ff @(posedge i_aes_clk) begin
    if (!i_aes_rst_n) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_aes_sub_bytes_seq_valid)         w_next = S_RUN;
      S_RUN:  if (r_cnt == CW'(BEATS - 1))           w_next = S_DONE;
      S_DONE: if (i_aes_sub_bytes_seq_ready)         w_next = S_IDLE;
      default:                                       w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_aes_clk) begin
    if (!i_aes_rst_n) begin
      r_cnt  <= '0;
      r_mode <= 1'b0;
      r_src  <= '0;
      r_res  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_aes_sub_bytes_seq_valid) begin
          r_src  <= i_aes_sub_bytes_seq_data_in;
          r_mode <= (INV_EN != 0) ? i_aes_sub_bytes_seq_inv : 1'b0;
          r_cnt  <= '0;
        end
        S_RUN: begin
          r_res[r_cnt] <= w_lane_out;
          r_cnt        <= (r_cnt == CW'(BEATS - 1)) ? '0 : r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_aes_sub_bytes_seq_ready    = (r_state == S_IDLE);
  assign o_aes_sub_bytes_seq_valid    = (r_state == S_DONE);
  assign o_aes_sub_bytes_seq_busy     = (r_state != S_IDLE);
  assign o_aes_sub_bytes_seq_data_out = r_res;
endmodule
